data_mem_lsu: RTL and testbench

//  Load/store sequencer: the initiator side of the DATA_MEM port (W, ADDR, DATA_WR, DATA_RD).

---
 rtl/salamander_mem_pkg.sv | 28 ++
 rtl/mem_addr_gen.sv | 37 +++
 rtl/data_mem_lsu.sv | 174 +++++++++++++++++
 tb/tb_data_mem_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/salamander_mem_pkg.sv
// Shared types for the data-memory load/store sequencer: command opcodes,
// FSM states and the memory-size helper.
package salamander_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_COPY  = 2'd2,
    OP_FILL  = 2'd3
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SINGLE  = 3'd1,
    ST_CP_RD   = 3'd2,
    ST_CP_WR   = 3'd3,
    ST_FILL_WR = 3'd4,
    ST_DONE    = 3'd5
  } lsu_state_e;

  localparam int DEF_ADDR_SIZE = 5;
  localparam int MEM_SIZE      = 2 ** DEF_ADDR_SIZE;

  function automatic int mem_size(input int addr_size);
    return 32'sd1 << addr_size;
  endfunction

endpackage

// File: rtl/mem_addr_gen.sv
// Block address generator: base + running index, wrapped to the address width,
// with a wide index counter so a full-memory block still terminates.
module mem_addr_gen
  import salamander_mem_pkg::*;
#(
  parameter int ADDR_SIZE = 5,
  parameter int LEN_SIZE  = ADDR_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  input  logic [ADDR_SIZE-1:0] i_base,
  input  logic [LEN_SIZE-1:0]  i_len,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic                 o_last
);

  logic [LEN_SIZE-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= r_idx + LEN_SIZE'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Truncating the sum gives the modulo-MEM_SIZE wrap for free.
  assign o_addr = i_base + r_idx[ADDR_SIZE-1:0];
  assign o_last = ((r_idx + LEN_SIZE'(1)) == i_len);

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store sequencer driving the DATA_MEM port: single LOAD/STORE and
// block COPY/FILL commands, one response pulse per command.
module data_mem_lsu
  import salamander_mem_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 5,
  parameter int LEN_SIZE  = ADDR_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_dst,
  input  logic [DATA_SIZE-1:0] req_data,
  input  logic [LEN_SIZE-1:0]  req_len,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mem_w,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam logic [LEN_SIZE-1:0] MEM_SIZE_L = LEN_SIZE'(mem_size(ADDR_SIZE));

  lsu_state_e           r_state;
  mem_op_e              r_op;
  logic [ADDR_SIZE-1:0] r_src;
  logic [ADDR_SIZE-1:0] r_dst;
  logic [ADDR_SIZE-1:0] r_last_addr;
  logic [DATA_SIZE-1:0] r_data;
  logic [DATA_SIZE-1:0] r_hold;
  logic [DATA_SIZE-1:0] r_rsp_data;
  logic [LEN_SIZE-1:0]  r_len;
  logic                 r_err;

  mem_op_e              w_req_op;
  logic                 w_accept;
  logic                 w_len_bad;
  logic                 w_len_zero;
  logic                 w_active;
  logic                 w_inc;
  logic                 w_last;
  logic [ADDR_SIZE-1:0] w_base;
  logic [ADDR_SIZE-1:0] w_addr;

  assign w_req_op   = mem_op_e'(req_op);
  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_len_bad  = (req_len > MEM_SIZE_L);
  assign w_len_zero = (req_len == '0);
  assign w_active   = (r_state == ST_SINGLE) || (r_state == ST_CP_RD) ||
                      (r_state == ST_CP_WR)  || (r_state == ST_FILL_WR);
  assign w_inc      = (r_state == ST_CP_WR) || (r_state == ST_FILL_WR);
  assign w_base     = (r_state == ST_CP_WR) ? r_dst : r_src;

  mem_addr_gen #(
    .ADDR_SIZE (ADDR_SIZE),
    .LEN_SIZE  (LEN_SIZE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_inc  (w_inc),
    .i_base (w_base),
    .i_len  (r_len),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_LOAD;
      r_src      <= '0;
      r_dst      <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_hold     <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= w_req_op;
            r_src  <= req_addr;
            r_dst  <= req_dst;
            r_data <= req_data;
            r_len  <= req_len;
            r_err  <= ((w_req_op == OP_COPY) || (w_req_op == OP_FILL)) && w_len_bad;
            case (w_req_op)
              OP_STORE, OP_FILL: r_rsp_data <= req_data;
              OP_COPY:           r_rsp_data <= '0;
              default:           r_rsp_data <= r_rsp_data;
            endcase
            case (w_req_op)
              OP_LOAD, OP_STORE: r_state <= ST_SINGLE;
              OP_COPY:           r_state <= (w_len_zero || w_len_bad) ? ST_DONE : ST_CP_RD;
              default:           r_state <= (w_len_zero || w_len_bad) ? ST_DONE : ST_FILL_WR;
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SINGLE: begin
          if (r_op == OP_LOAD) begin
            r_rsp_data <= mem_rdata;
          end else begin
            r_rsp_data <= r_rsp_data;
          end
          r_state <= ST_DONE;
        end
        ST_CP_RD: begin
          r_hold  <= mem_rdata;
          r_state <= ST_CP_WR;
        end
        ST_CP_WR: begin
          r_rsp_data <= r_hold;
          r_state    <= w_last ? ST_DONE : ST_CP_RD;
        end
        ST_FILL_WR: r_state <= w_last ? ST_DONE : ST_FILL_WR;
        ST_DONE:    r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // mem_addr keeps showing the last driven address while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_addr <= '0;
    end else if (w_active) begin
      r_last_addr <= w_addr;
    end else begin
      r_last_addr <= r_last_addr;
    end
  end

  always_comb begin
    mem_w     = 1'b0;
    mem_wdata = '0;
    case (r_state)
      ST_SINGLE: begin
        mem_w     = (r_op == OP_STORE);
        mem_wdata = (r_op == OP_STORE) ? r_data : '0;
      end
      ST_CP_WR: begin
        mem_w     = 1'b1;
        mem_wdata = r_hold;
      end
      ST_FILL_WR: begin
        mem_w     = 1'b1;
        mem_wdata = r_data;
      end
      default: begin
        mem_w     = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  assign mem_addr  = w_active ? w_addr : r_last_addr;
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_err   = (r_state == ST_DONE) && r_err;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu paired with a behavioural DATA_MEM (reset to mem[i]=i).
module tb_data_mem_lsu;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_addr;
  logic [4:0] req_dst;
  logic [7:0] req_data;
  logic [5:0] req_len;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       mem_w;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       mem_init;
  logic [7:0] mem [0:31];
  int         ref_mem [0:31];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_dst   (req_dst),
    .req_data  (req_data),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // DATA_MEM: combinational read, write on posedge
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (mem_w) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    int op; int a; int d; int dat; int len;
    int exp_data; int exp_err; int exp_lat; int exp_wr;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string tag, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s: actual=%0d required=%0d", tag, name, act, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < 32; i++) if (int'(mem[i]) != ref_mem[i]) mism++;
    chk(tag, "mem_mismatch_words", mism, 0);
  endtask

  // Reference model: applies the command to ref_mem and predicts the response.
  task automatic model_cmd(input int op, input int a, input int d, input int dat, input int len,
                           output int e_data, output bit e_chk, output int e_err,
                           output int e_lat, output int e_wr);
    e_data = 0; e_chk = 1'b1; e_err = 0; e_lat = 1; e_wr = 0;
    if (op == 0) begin
      e_data = ref_mem[a]; e_lat = 2;
    end else if (op == 1) begin
      ref_mem[a] = dat; e_data = dat; e_lat = 2; e_wr = 1;
    end else if (len > 32) begin
      e_err = 1; e_chk = 1'b0;
    end else if (op == 2) begin
      for (int i = 0; i < len; i++) begin
        ref_mem[(d + i) % 32] = ref_mem[(a + i) % 32];
        e_data = ref_mem[(d + i) % 32];
      end
      e_lat = 2 * len + 1; e_wr = len;
    end else begin
      for (int i = 0; i < len; i++) ref_mem[(a + i) % 32] = dat;
      e_data = dat; e_lat = len + 1; e_wr = len;
    end
  endtask

  // Issues one command from a negedge in IDLE and checks its response.
  task automatic do_cmd(input string tag, input int op, input int a, input int d, input int dat,
                        input int len, input int e_data, input bit e_chk, input int e_err,
                        input int e_lat, input int e_wr);
    int lat = 0;
    int wr  = 0;
    bit got = 1'b0;
    int got_data = 0;
    int got_err = 0;
    chk(tag, "req_ready_before", int'(req_ready), 1);
    req_valid = 1'b1; req_op = op[1:0]; req_addr = a[4:0]; req_dst = d[4:0];
    req_data = dat[7:0]; req_len = len[5:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op   = 2'($urandom_range(0, 3));
    req_addr = 5'($urandom_range(0, 31));
    req_dst  = 5'($urandom_range(0, 31));
    req_data = 8'($urandom_range(0, 255));
    req_len  = 6'($urandom_range(0, 63));
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (mem_w) wr++;
      if (rsp_valid) begin
        got = 1'b1; got_data = int'(rsp_data); got_err = int'(rsp_err);
      end
    end
    chk(tag, "rsp_seen", int'(got), 1);
    chk(tag, "latency", lat, e_lat);
    chk(tag, "rsp_err", got_err, e_err);
    if (e_chk) chk(tag, "rsp_data", got_data, e_data);
    chk(tag, "write_cycles", wr, e_wr);
    @(negedge clk);
    chk(tag, "rsp_pulse_end", int'(rsp_valid), 0);
    chk(tag, "req_ready_after", int'(req_ready), 1);
    chk_mem(tag);
  endtask

  initial begin
    int e_data, e_err, e_lat, e_wr;
    bit e_chk;

    vecs[0]  = '{0,  7,  0, 8'h00,  0, 7,     0, 2,  0};
    vecs[1]  = '{2,  0,  8, 8'h00,  4, 3,     0, 9,  4};
    vecs[2]  = '{0,  8,  0, 8'h00,  0, 0,     0, 2,  0};
    vecs[3]  = '{0, 11,  0, 8'h00,  0, 3,     0, 2,  0};
    vecs[4]  = '{2,  4,  5, 8'h00,  3, 4,     0, 7,  3};
    vecs[5]  = '{0,  7,  0, 8'h00,  0, 4,     0, 2,  0};
    vecs[6]  = '{1,  3,  0, 8'hA5,  0, 8'hA5, 0, 2,  1};
    vecs[7]  = '{0,  3,  0, 8'h00,  0, 8'hA5, 0, 2,  0};
    vecs[8]  = '{3, 30,  0, 8'h11,  4, 8'h11, 0, 5,  4};
    vecs[9]  = '{0,  2,  0, 8'h00,  0, 2,     0, 2,  0};
    vecs[10] = '{0,  0,  0, 8'h00,  0, 8'h11, 0, 2,  0};
    vecs[11] = '{2,  1, 20, 8'h00,  0, 0,     0, 1,  0};
    vecs[12] = '{2,  1, 20, 8'h00, 33, 0,     1, 1,  0};
    vecs[13] = '{3,  9,  0, 8'h77,  0, 8'h77, 0, 1,  0};
    vecs[14] = '{3, 16,  0, 8'h5A, 32, 8'h5A, 0, 33, 32};
    vecs[15] = '{0,  5,  0, 8'h00,  0, 8'h5A, 0, 2,  0};
    vecs[16] = '{3,  2,  0, 8'h33, 34, 0,     1, 1,  0};
    vecs[17] = '{2, 20, 28, 8'h00, 32, 8'h5A, 0, 65, 32};

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_addr = 5'd0; req_dst = 5'd0;
    req_data = 8'd0; req_len = 6'd0;
    for (int i = 0; i < 32; i++) ref_mem[i] = i;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("reset", "rsp_valid", int'(rsp_valid), 0);
    chk("reset", "rsp_err",   int'(rsp_err),   0);
    chk("reset", "rsp_data",  int'(rsp_data),  0);
    chk("reset", "mem_w",     int'(mem_w),     0);
    chk("reset", "mem_addr",  int'(mem_addr),  0);
    chk("reset", "mem_wdata", int'(mem_wdata), 0);
    chk("reset", "busy",      int'(busy),      0);
    chk("reset", "req_ready", int'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 18; v++) begin
      model_cmd(vecs[v].op, vecs[v].a, vecs[v].d, vecs[v].dat, vecs[v].len,
                e_data, e_chk, e_err, e_lat, e_wr);
      do_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].d, vecs[v].dat,
             vecs[v].len, vecs[v].exp_data, (vecs[v].exp_err == 0), vecs[v].exp_err,
             vecs[v].exp_lat, vecs[v].exp_wr);
    end

    // Reset in the fourth cycle of a 10-word FILL: exactly three words land.
    req_valid = 1'b1; req_op = 2'd3; req_addr = 5'd12; req_dst = 5'd0;
    req_data = 8'hC3; req_len = 6'd10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mid", "mem_w_before", int'(mem_w), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid", "mem_w",     int'(mem_w),     0);
    chk("rst_mid", "busy",      int'(busy),      0);
    chk("rst_mid", "req_ready", int'(req_ready), 1);
    chk("rst_mid", "rsp_valid", int'(rsp_valid), 0);
    chk("rst_mid", "rsp_data",  int'(rsp_data),  0);
    chk("rst_mid", "mem_addr",  int'(mem_addr),  0);
    chk("rst_mid", "mem_wdata", int'(mem_wdata), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 12; i < 15; i++) ref_mem[i] = 8'hC3;
    chk("rst_mid", "word15_untouched", int'(mem[15]), 8'h5A);
    chk_mem("rst_mid");

    for (int n = 0; n < 150; n++) begin
      int op, a, d, dat, len, r;
      op  = $urandom_range(0, 3);
      a   = $urandom_range(0, 31);
      d   = $urandom_range(0, 31);
      dat = $urandom_range(0, 255);
      r   = $urandom_range(0, 9);
      if (r == 0)      len = 0;
      else if (r == 1) len = $urandom_range(33, 63);
      else if (r == 2) len = 32;
      else             len = $urandom_range(1, 12);
      model_cmd(op, a, d, dat, len, e_data, e_chk, e_err, e_lat, e_wr);
      do_cmd($sformatf("rnd%0d", n), op, a, d, dat, len, e_data, e_chk, e_err, e_lat, e_wr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
